multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

- Main control FSM for the multi-cycle MIPS datapath.
- Decodes the instruction opcode and produces the `ALUop` code consumed by the ALU control unit. Also produces all datapath select and enable strobes.
- Takes the ALU `Zero` flag back in to resolve `beq`.
- Sits between the instruction register and the ALU/ALU-control pair. Handshakes with instruction/data memory through `mem_ready`.

## Interface
Parameters:
- `OP_R`, 6'b000000, R-type opcode
- `OP_LW`, 6'b100011, load word
- `OP_SW`, 6'b101011, store word
- `OP_BEQ`, 6'b000100, branch-if-equal
- `OP_J`, 6'b000010, jump (only used when `MULTICYCLE_JUMP_EN` is defined)

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: IR[31:26], sampled in DECODE.
- `Zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `ALUop` out 2: 00 add, 01 sub, 10 use funct.
- `ALUSrcA` out 1: 0 = PC, 1 = register A.
- `ALUSrcB` out 2: 00 = B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- `PCSource` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `PCWrite` out 1: effective PC write enable, with branch condition already folded in.
- `IorD` out 1: 0 = PC address, 1 = ALUOut address.
- `MemRead`, `MemWrite`, `IRWrite`, `RegWrite` out 1 each: strobes.
- `RegDst` out 1: 1 = rd, 0 = rt.
- `MemtoReg` out 1: 1 = MDR, 0 = ALUOut.
- `illegal_op` out 1: one-cycle pulse on an undecodable opcode.
- `state` out 4: current state, for debug.

## Operation
State encoding: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, RWB=8, BRANCH=9, JUMP=10. Codes 11–15 are unused; if reached, the FSM returns to FETCH on the next edge.

Outputs are Moore, decoded from `state`. The exceptions are strobes gated by `mem_ready` or `Zero`. Any output not listed for a state is 0.

Per-state behaviour and transitions:
- **IDLE:** all outputs 0. Next state is FETCH unconditionally.
- **FETCH:**
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=00.
  - IRWrite=PCWrite=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- **DECODE:**
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUop=00 (branch target into ALUOut).
  - Next state by opcode: lw/sw → MEMADR, R → EXEC, beq → BRANCH, j → JUMP (build-dependent).
  - Any other opcode → FETCH, with illegal_op=1 for this cycle.
- **MEMADR:** ALUSrcA=1, ALUSrcB=10, ALUop=00. Next state is MEMRD for lw, MEMWR for sw; the opcode is held stable by the IR.
- **MEMRD:** MemRead=1, IorD=1. Waits for mem_ready, then → MEMWB.
- **MEMWB:** RegWrite=1, RegDst=0, MemtoReg=1. Next state FETCH.
- **MEMWR:** MemWrite=1, IorD=1. Waits for mem_ready, then → FETCH.
- **EXEC:** ALUSrcA=1, ALUSrcB=00, ALUop=10. Next state RWB.
- **RWB:** RegWrite=1, RegDst=1, MemtoReg=0. Next state FETCH.
- **BRANCH:** ALUSrcA=1, ALUSrcB=00, ALUop=01, PCSource=01, PCWrite=Zero. Next state FETCH.
- **JUMP:** PCSource=10, PCWrite=1. Next state FETCH.

## Timing
- **Reset:** rst_n low forces state=IDLE immediately, so all outputs go 0 asynchronously.
  - Reset asserted mid-access drops MemRead/MemWrite the same cycle. The in-flight access is abandoned.
  - After release: IDLE for one edge, then FETCH.
- **Cycle counts, with mem_ready=1 on first request:** R = 4, lw = 5, sw = 4, beq = 3, j = 3.
  - Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- **Memory handshake:**
  - mem_ready is sampled only in FETCH, MEMRD and MEMWR; it is ignored elsewhere.
  - MemRead/MemWrite/IorD stay stable for the whole wait.
- **Zero** is used combinationally in BRANCH only. It must settle before the clock edge; no registering.
- **opcode** is sampled in DECODE and MEMADR. A change in any other state has no effect.

## Configuration
Macro: `MULTICYCLE_JUMP_EN`.
- **Defined:** opcode `OP_J` in DECODE → JUMP state as specified above.
- **Undefined:** the JUMP state is not built. `OP_J` is treated as illegal: DECODE → FETCH with an illegal_op pulse, and PC is not written.

## Test plan
1. **Reset release:** hold rst_n=0 for 3 cycles, then release → state 0 then 1; all outputs 0 while in reset; MemRead=1 from the first FETCH cycle.
2. **R-type add:** opcode=000000, mem_ready=1 → states 1,2,7,8,1; ALUop=10 in EXEC; RegWrite=1, RegDst=1 in RWB.
3. **lw with memory stall:** opcode=100011, mem_ready=0 for 2 cycles in MEMRD → states 1,2,3,4,4,4,5,1; IorD=1 throughout MEMRD; MemtoReg=1 in MEMWB.
4. **beq both ways:**
   - Zero=1 in BRANCH → PCWrite=1, PCSource=01, ALUop=01.
   - Zero=0 → PCWrite=0.
   - Both cases return to FETCH.
5. **Illegal/jump opcode:** opcode=000010 with macro undefined → illegal_op=1 for one cycle in DECODE, then FETCH. With macro defined → JUMP with PCWrite=1, PCSource=10.
6. **Reset mid-sw:** assert rst_n=0 during MEMWR while mem_ready=0 → MemWrite drops to 0 immediately and state=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath: opcode decode, ALUop and datapath strobes.
// Optional JUMP state is built only when MULTICYCLE_JUMP_EN is defined.
module multicycle_ctrl #(
  parameter logic [5:0] OP_R   = 6'b000000,
  parameter logic [5:0] OP_LW  = 6'b100011,
  parameter logic [5:0] OP_SW  = 6'b101011,
  parameter logic [5:0] OP_BEQ = 6'b000100,
  parameter logic [5:0] OP_J   = 6'b000010
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic [1:0] ALUop,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10
  } state_e;

  state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d    = state_q;
    ALUop      = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSource   = 2'b00;
    PCWrite    = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    illegal_op = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      // PC+4 is written back in the same cycle the instruction lands in IR
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end

      S_DECODE: begin
        ALUSrcB = 2'b11;
        if (opcode == OP_LW || opcode == OP_SW) begin
          state_d = S_MEMADR;
        end else if (opcode == OP_R) begin
          state_d = S_EXEC;
        end else if (opcode == OP_BEQ) begin
          state_d = S_BRANCH;
`ifdef MULTICYCLE_JUMP_EN
        end else if (opcode == OP_J) begin
          state_d = S_JUMP;
`else
        end else if (opcode == OP_J) begin
          state_d    = S_FETCH;
          illegal_op = 1'b1;
`endif
        end else begin
          state_d    = S_FETCH;
          illegal_op = 1'b1;
        end
      end

      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end

      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = S_FETCH;
      end

      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end

      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUop   = 2'b10;
        state_d = S_RWB;
      end

      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        state_d  = S_FETCH;
      end

      // Zero must be settled before the edge; the branch decision is not registered
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUop    = 2'b01;
        PCSource = 2'b01;
        PCWrite  = Zero;
        state_d  = S_FETCH;
      end

`ifdef MULTICYCLE_JUMP_EN
      S_JUMP: begin
        PCSource = 2'b10;
        PCWrite  = 1'b1;
        state_d  = S_FETCH;
      end
`endif

      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: instruction-level model expands each instruction
// into its expected per-cycle output vectors; honours MULTICYCLE_JUMP_EN like the DUT.
module tb_multicycle_ctrl;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] JUNK    = 6'b111111;

  localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_MEMADR = 3, P_MEMRD = 4,
                 P_MEMWB = 5, P_MEMWR = 6, P_EXEC = 7, P_RWB = 8, P_BRANCH = 9, P_JUMP = 10;

`ifdef MULTICYCLE_JUMP_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] st;
    logic [1:0] aluop;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] pcsrc;
    logic       pcw, iord, mrd, mwr, irw, rgw, rdst, m2r, ill;
  } vec_t;

  logic       clk, rst_n;
  logic [5:0] opcode;
  logic       Zero, mem_ready;
  logic [1:0] ALUop, ALUSrcB, PCSource;
  logic       ALUSrcA, PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg;
  logic       illegal_op;
  logic [3:0] state;

  int vectors = 0;
  int miscompares = 0;
  vec_t exp_q[$];
  logic [3:0] hist[$];

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .Zero(Zero), .mem_ready(mem_ready),
    .ALUop(ALUop), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .illegal_op(illegal_op), .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // What the datapath must see in a given phase of an instruction, given the live inputs
  function automatic vec_t expect_vec(input int ph, input logic mr, input logic z, input logic ill);
    vec_t v;
    v = '0;
    v.st = ph[3:0];
    case (ph)
      P_FETCH:  begin v.mrd = 1; v.srcb = 2'b01; v.irw = mr; v.pcw = mr; end
      P_DECODE: begin v.srcb = 2'b11; v.ill = ill; end
      P_MEMADR: begin v.srca = 1; v.srcb = 2'b10; end
      P_MEMRD:  begin v.mrd = 1; v.iord = 1; end
      P_MEMWB:  begin v.rgw = 1; v.m2r = 1; end
      P_MEMWR:  begin v.mwr = 1; v.iord = 1; end
      P_EXEC:   begin v.srca = 1; v.aluop = 2'b10; end
      P_RWB:    begin v.rgw = 1; v.rdst = 1; end
      P_BRANCH: begin v.srca = 1; v.aluop = 2'b01; v.pcsrc = 2'b01; v.pcw = z; end
      P_JUMP:   begin v.pcsrc = 2'b10; v.pcw = 1; end
      default:  ;
    endcase
    return v;
  endfunction

  always @(negedge clk) begin
    vec_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {state, ALUop, ALUSrcA, ALUSrcB, PCSource, PCWrite, IorD, MemRead, MemWrite,
           IRWrite, RegWrite, RegDst, MemtoReg, illegal_op};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("[TB] FAIL cyc_chk t=%0t: got %h, expected %h", $time, a, e);
      end
      hist.push_back(state);
    end
  end

  task automatic checkOutput(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // seq holds the expected state codes one nibble each, first state in the low nibble
  task automatic checkHist(input string name, input logic [31:0] seq, input int len);
    checkOutput({name, "_len"}, hist.size(), len);
    for (int i = 0; i < len; i++)
      if (i < hist.size()) checkOutput({name, "_seq"}, int'(hist[i]), int'(seq[i*4 +: 4]));
  endtask

  task automatic step(input int ph, input logic [5:0] op, input logic mr, input logic z,
                      input logic ill);
    @(posedge clk);
    #1;
    opcode    = op;
    mem_ready = mr;
    Zero      = z;
    exp_q.push_back(expect_vec(ph, mr, z, ill));
    @(negedge clk);
    #1;
  endtask

  // Expands one instruction into its cycle sequence; unused inputs carry junk to prove they are ignored
  task automatic applyStimulus(input logic [5:0] op, input logic z, input int fwait, input int mwait);
    logic legal;
    legal = (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
            (JUMP_EN && op == OP_J);
    for (int i = 0; i < fwait; i++) step(P_FETCH, JUNK, 1'b0, 1'b1, 1'b0);
    step(P_FETCH, JUNK, 1'b1, 1'b1, 1'b0);
    step(P_DECODE, op, 1'b0, 1'b1, !legal);
    if (op == OP_LW) begin
      step(P_MEMADR, op, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < mwait; i++) step(P_MEMRD, JUNK, 1'b0, 1'b1, 1'b0);
      step(P_MEMRD, JUNK, 1'b1, 1'b1, 1'b0);
      step(P_MEMWB, JUNK, 1'b0, 1'b1, 1'b0);
    end else if (op == OP_SW) begin
      step(P_MEMADR, op, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < mwait; i++) step(P_MEMWR, JUNK, 1'b0, 1'b1, 1'b0);
      step(P_MEMWR, JUNK, 1'b1, 1'b1, 1'b0);
    end else if (op == OP_R) begin
      step(P_EXEC, JUNK, 1'b0, 1'b1, 1'b0);
      step(P_RWB, JUNK, 1'b0, 1'b1, 1'b0);
    end else if (op == OP_BEQ) begin
      step(P_BRANCH, JUNK, 1'b0, z, 1'b0);
    end else if (legal) begin
      step(P_JUMP, JUNK, 1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic releaseReset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back(expect_vec(P_IDLE, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    opcode    = OP_R;
    mem_ready = 1'b1;
    Zero      = 1'b1;

    repeat (3) step(P_IDLE, JUNK, 1'b1, 1'b1, 1'b0);
    releaseReset();

    hist.delete();
    applyStimulus(OP_R, 1'b1, 0, 0);
    checkHist("r_type", 32'h0000_8721, 4);

    hist.delete();
    applyStimulus(OP_LW, 1'b1, 0, 2);
    checkHist("lw_stall", 32'h0544_4321, 7);

    hist.delete();
    applyStimulus(OP_SW, 1'b1, 0, 0);
    checkHist("sw", 32'h0000_6321, 4);

    hist.delete();
    applyStimulus(OP_BEQ, 1'b1, 0, 0);
    checkHist("beq_taken", 32'h0000_0921, 3);

    applyStimulus(OP_BEQ, 1'b0, 0, 0);

    hist.delete();
    applyStimulus(OP_J, 1'b1, 0, 0);
    if (JUMP_EN) checkHist("jump", 32'h0000_0A21, 3);
    else         checkHist("j_illegal", 32'h0000_0021, 2);

    hist.delete();
    applyStimulus(OP_ADDI, 1'b1, 0, 0);
    checkHist("illegal", 32'h0000_0021, 2);

    applyStimulus(OP_SW, 1'b1, 2, 1);
    applyStimulus(OP_R, 1'b0, 1, 0);

    hist.delete();
    applyStimulus(OP_LW, 1'b0, 0, 0);
    checkHist("lw_fast", 32'h0005_4321, 5);

    step(P_FETCH, JUNK, 1'b1, 1'b1, 1'b0);
    step(P_DECODE, OP_SW, 1'b0, 1'b1, 1'b0);
    step(P_MEMADR, OP_SW, 1'b0, 1'b1, 1'b0);
    step(P_MEMWR, JUNK, 1'b0, 1'b1, 1'b0);
    step(P_MEMWR, JUNK, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_sw_memwrite", int'(MemWrite), 0);
    checkOutput("rst_mid_sw_iord", int'(IorD), 0);
    checkOutput("rst_mid_sw_state", int'(state), 0);
    repeat (2) step(P_IDLE, JUNK, 1'b1, 1'b1, 1'b0);
    releaseReset();

    hist.delete();
    applyStimulus(OP_R, 1'b1, 0, 0);
    checkHist("r_after_reset", 32'h0000_8721, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
